// File: rtl/seq_pkg.sv
// Shared constants for the serializer: FSM state encoding and the default word width.
package seq_pkg;

  localparam int SEQ_WIDTH_DEFAULT = 8;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer so that consecutive
// words leave back to back on seq_out with no idle cycle between them.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam int OUT_BIT = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  logic             state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] sr_shifted;

  assign accept = data_valid && !hold_full_q;
  assign load   = (state_q == STATE_IDLE) || (bit_cnt_q == '0);

  assign sr_shifted = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (load) begin
      // The held word always goes first; a fresh word only refills the hold slot.
      if (hold_full_q) begin
        sr_d        = hold_q;
        bit_cnt_d   = LAST_CNT;
        state_d     = STATE_SHIFT;
        hold_full_d = accept;
        if (accept) begin
          hold_d = data_in;
        end
      end else if (accept) begin
        sr_d      = data_in;
        bit_cnt_d = LAST_CNT;
        state_d   = STATE_SHIFT;
      end else begin
        sr_d      = '0;
        bit_cnt_d = '0;
        state_d   = STATE_IDLE;
      end
    end else begin
      sr_d      = sr_shifted;
      bit_cnt_d = bit_cnt_q - CW'(1);
      if (accept) begin
        hold_d      = data_in;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // SR is cleared whenever the FSM returns to IDLE, so its output bit is already 0 there.
  assign seq_out    = sr_q[OUT_BIT];
  assign seq_valid  = state_q;
  assign busy       = state_q | hold_full_q;
  assign data_ready = ~hold_full_q;

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, is the parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 data_in  input  WIDTH  parallel word offered by the upstream producer.
REQ-006 data_valid  input  1  data_in is valid this cycle.
REQ-007 data_ready  output  1  the block accepts data_in this cycle.
REQ-008 seq_out  output  1  serial bit stream, connected directly to the seq_in port of seq101_detector.
REQ-009 seq_valid  output  1  seq_out carries a payload bit this cycle.
REQ-010 busy  output  1  a word is being shifted or a word is held pending.

Function
REQ-011 A word SHALL be accepted only on a rising edge where data_valid and data_ready are both 1; data_in is ignored otherwise.
REQ-012 The block SHALL contain one shift register (SR), a down-counter bit_cnt of width clog2(WIDTH), and a one-entry hold register with flag hold_full.
REQ-013 The FSM SHALL have two states: IDLE (SR empty) and SHIFT (SR driving seq_out).
REQ-014 A load event SHALL occur on any edge where state is IDLE, or state is SHIFT and bit_cnt equals 0 (last bit).
REQ-015 At a load event, SR SHALL load from the hold register if hold_full is 1, else from an accepted data_in; bit_cnt SHALL load WIDTH-1; next state SHALL be SHIFT.
REQ-016 At a load event with no word available, next state SHALL be IDLE.
REQ-017 An accepted word not consumed by a load event SHALL be written to the hold register, and hold_full SHALL set.
REQ-018 If hold_full is 1 and a word is accepted at a load event, the held word goes to SR and the new word to the hold register; hold_full stays 1.
REQ-019 hold_full SHALL clear when the held word moves to SR and no new word is accepted on that edge.
REQ-020 data_ready SHALL equal NOT hold_full (combinational from registered state only).
REQ-021 In SHIFT, seq_out SHALL present SR bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0); SR shifts by one each cycle; bit_cnt decrements by 1.
REQ-022 First bit of an accepted word SHALL appear on seq_out the cycle after acceptance when the SR is free (latency 1 cycle).
REQ-023 Back-to-back words SHALL stream with no idle cycle between the last bit of one word and the first bit of the next.
REQ-024 seq_valid SHALL be 1 exactly in SHIFT; it SHALL be high for WIDTH cycles per word.
REQ-025 In IDLE, seq_out SHALL be 0 and seq_valid SHALL be 0.
REQ-026 busy SHALL equal (state == SHIFT) OR hold_full.
REQ-027 seq_out and seq_valid SHALL be register outputs with no combinational path from data_in or data_valid.

Reset
REQ-028 When rst is 1: state IDLE, bit_cnt 0, SR 0, hold_full 0; seq_out 0, seq_valid 0, busy 0, data_ready 1 on the following cycle.
REQ-029 rst SHALL take priority over acceptance; a word offered during rst is dropped.
REQ-030 A reset mid-word SHALL discard the SR and hold contents; no remaining bits of either word are emitted.

Structure
REQ-031 Shared package seq_pkg SHALL hold the FSM state encoding (IDLE=1'b0, SHIFT=1'b1) and the WIDTH default constant.
REQ-032 No sub-module; SR, hold register, counter and FSM are inline in seq_serializer.

Verification
REQ-033 Reset, then accept 8'hA5 with MSB_FIRST=1 -> seq_out 1,0,1,0,0,1,0,1 on the 8 cycles after accept; seq_valid high exactly 8 cycles; then seq_out=0, seq_valid=0.
REQ-034 data_valid held high with 8'h5A, 8'hFF, 8'h00 -> 24 contiguous seq_valid cycles with no gap; data_ready drops low while hold_full; busy falls 1 cycle after the last bit.
REQ-035 MSB_FIRST=0, accept 8'h01 -> seq_out 1 then seven 0s.
REQ-036 Assert rst after the 3rd bit of 8'hFF with 8'h0F held -> seq_valid=0 and seq_out=0 from the next cycle; busy 0; data_ready 1; no further bits are emitted.
REQ-037 Drive seq101_detector from seq_out and accept 8'h05 (00000101) -> exactly one det_o pulse. Accept 8'h00 -> no det_o pulse.
REQ-038 Hold data_valid low during shifting -> data_ready stays 1, no spurious acceptance, and the stream is unchanged.
